// File: rtl/demux_seq_ctrl.sv
// Sequenced 1-to-16 demultiplexer: sweeps the enabled channels in ascending order,
// dwelling a programmable number of cycles on each and capturing the serial bit per channel.
module demux_seq_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               cont,
  input  logic [15:0]        mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               in,
  output logic [3:0]         sel,
  output logic               en,
  output logic [15:0]        y,
  output logic [15:0]        y_hold,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [3:0]         sel_reg, sel_next;
  logic [15:0]        mask_q_reg, mask_q_next;
  logic [DWELL_W-1:0] dwell_q_reg, dwell_q_next;
  logic [DWELL_W-1:0] cnt_reg, cnt_next;
  logic [15:0]        y_hold_reg, y_hold_next;
  logic               capture;
  logic               above_found;
  logic [3:0]         above_idx;

  function automatic logic [3:0] lowest_set(input logic [15:0] m);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Nearest enabled channel strictly above the current one.
  always_comb begin
    above_found = 1'b0;
    above_idx   = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (mask_q_reg[i] && (i > int'(sel_reg))) begin
        above_found = 1'b1;
        above_idx   = 4'(i);
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    sel_next     = sel_reg;
    mask_q_next  = mask_q_reg;
    dwell_q_next = dwell_q_reg;
    cnt_next     = cnt_reg;
    capture      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!abort && start && (|mask)) begin
          mask_q_next  = mask;
          dwell_q_next = dwell;
          sel_next     = lowest_set(mask);
          cnt_next     = '0;
          state_next   = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (cnt_reg == dwell_q_reg) begin
          capture  = 1'b1;
          cnt_next = '0;
          if (above_found) begin
            sel_next = above_idx;
          end else if (cont) begin
            // Sweep wrap in continuous mode re-samples the channel set and dwell.
            mask_q_next  = mask;
            dwell_q_next = dwell;
            if (|mask) begin
              sel_next = lowest_set(mask);
            end else begin
              state_next = IDLE;
            end
          end else begin
            state_next = FIN;
          end
        end else begin
          cnt_next = cnt_reg + {{(DWELL_W-1){1'b0}}, 1'b1};
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    y_hold_next = y_hold_reg;
    if (capture) y_hold_next[sel_reg] = in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      sel_reg     <= 4'd0;
      mask_q_reg  <= 16'h0000;
      dwell_q_reg <= '0;
      cnt_reg     <= '0;
      y_hold_reg  <= 16'h0000;
    end else begin
      state_reg   <= state_next;
      sel_reg     <= sel_next;
      mask_q_reg  <= mask_q_next;
      dwell_q_reg <= dwell_q_next;
      cnt_reg     <= cnt_next;
      y_hold_reg  <= y_hold_next;
    end
  end

  assign sel    = sel_reg;
  assign en     = (state_reg == RUN);
  assign busy   = (state_reg == RUN) || (state_reg == FIN);
  assign done   = (state_reg == FIN);
  assign y_hold = y_hold_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_y
      assign y[gi] = en && (sel_reg == 4'(gi)) && in;
    end
  endgenerate

endmodule

// File: tb/tb_demux_seq_ctrl.sv
// Self-checking bench for demux_seq_ctrl: per-cycle scoreboard of expected outputs built
// from sweep descriptions, a table of single sweeps, and hand-built multi-cycle sequences.
module tb_demux_seq_ctrl;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, start, abort, cont, in;
  logic [15:0]   mask;
  logic [DW-1:0] dwell;
  logic [3:0]    sel;
  logic          en, busy, done;
  logic [15:0]   y, y_hold;

  demux_seq_ctrl #(.DWELL_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cont(cont),
    .mask(mask), .dwell(dwell), .in(in),
    .sel(sel), .en(en), .y(y), .y_hold(y_hold), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          start, abort, cont, rst, in_v;
    logic [15:0]   mask;
    logic [DW-1:0] dwell;
    logic [3:0]    sel;
    logic          en, busy, done, cap;
  } cyc_t;

  typedef struct {
    string         name;
    logic [15:0]   mask;
    logic [DW-1:0] dwell;
    bit            tog;
    int            exp_done;
  } vec_t;

  cyc_t        sb[$];
  vec_t        vecs[6];
  int          checks = 0;
  int          passed = 0;
  logic [15:0] exp_hold = 16'h0000;
  logic [3:0]  last_sel = 4'd0;
  bit          in_ph = 1'b0;
  int          fd;

  task automatic push(input logic st, ab, ct, rs, iv, input logic [15:0] m,
                      input logic [DW-1:0] d, input logic [3:0] s,
                      input logic e, b, dn, cp);
    cyc_t c;
    c.start = st; c.abort = ab; c.cont = ct; c.rst = rs; c.in_v = iv;
    c.mask = m; c.dwell = d; c.sel = s; c.en = e; c.busy = b; c.done = dn; c.cap = cp;
    sb.push_back(c);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One sweep over the channels of m: each enabled channel for d+1 cycles, ascending.
  task automatic push_run(input logic [15:0] m, input logic [DW-1:0] d, input logic ct,
                          input bit tog, input bit noise,
                          input logic [15:0] nm, input logic [DW-1:0] nd);
    logic iv, st;
    logic [15:0] dm;
    logic [DW-1:0] dd;
    for (int ch = 0; ch < 16; ch++) begin
      if (m[ch]) begin
        for (int c = 0; c <= int'(d); c++) begin
          in_ph = ~in_ph;
          iv = tog ? in_ph : rbit();
          st = noise ? rbit() : 1'b0;
          dm = noise ? 16'($urandom) : nm;
          dd = noise ? DW'($urandom) : nd;
          push(st, 1'b0, ct, 1'b0, iv, dm, dd, 4'(ch), 1'b1, 1'b1, 1'b0, (c == int'(d)));
          last_sel = 4'(ch);
        end
      end
    end
  endtask

  task automatic push_start(input logic [15:0] m, input logic [DW-1:0] d, input logic ct);
    push(1'b1, 1'b0, ct, 1'b0, rbit(), m, d, last_sel, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_idle(input int n, input logic st, input logic [15:0] m);
    for (int i = 0; i < n; i++)
      push(st, 1'b0, 1'b0, 1'b0, rbit(), m, '0, last_sel, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // FIN cycle (start asserted, must be ignored) followed by one IDLE cycle.
  task automatic push_tail();
    push(1'b1, 1'b0, 1'b0, 1'b0, rbit(), 16'($urandom), DW'($urandom), last_sel,
         1'b0, 1'b1, 1'b1, 1'b0);
    push_idle(1, 1'b0, 16'hFFFF);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Drains the scoreboard: one entry per clock cycle, stimulus applied then outputs compared.
  task automatic run_sb(input string name, output int first_done);
    cyc_t c;
    logic [15:0] exp_y;
    int k;
    k = 0;
    first_done = -1;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      start = c.start; abort = c.abort; cont = c.cont; rst = c.rst;
      in = c.in_v; mask = c.mask; dwell = c.dwell;
      #1;
      exp_y = c.en ? (16'(c.in_v) << c.sel) : 16'h0000;
      checks++;
      if ({sel, en, busy, done, y, y_hold} === {c.sel, c.en, c.busy, c.done, exp_y, exp_hold})
        passed++;
      else
        $display("FAIL %s cycle %0d: got sel=%0d en=%b busy=%b done=%b y=%h y_hold=%h, expected sel=%0d en=%b busy=%b done=%b y=%h y_hold=%h",
                 name, k, sel, en, busy, done, y, y_hold,
                 c.sel, c.en, c.busy, c.done, exp_y, exp_hold);
      if (done === 1'b1 && first_done < 0) first_done = k;
      if (c.rst) exp_hold = 16'h0000;
      else if (c.cap) exp_hold[c.sel] = c.in_v;
      @(posedge clk);
      #1;
      k++;
    end
    $display("sweep %s: %0d cycles, first done at cycle %0d", name, k, first_done);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{"full_d0",      16'hFFFF, 8'd0,   1'b1, 17};
    vecs[1] = '{"spread_d3",    16'h8421, 8'd3,   1'b0, 17};
    vecs[2] = '{"single_lo",    16'h0001, 8'd0,   1'b0, 2};
    vecs[3] = '{"single_hi_d2", 16'h8000, 8'd2,   1'b1, 4};
    vecs[4] = '{"pair_dmax",    16'h00A0, 8'd255, 1'b0, 513};
    vecs[5] = '{"empty_mask",   16'h0000, 8'd5,   1'b0, -1};

    rst = 1'b1; start = 1'b0; abort = 1'b0; cont = 1'b0; in = 1'b0;
    mask = 16'h0000; dwell = '0;
    repeat (2) @(posedge clk);
    #1;

    // Single sweeps; start, mask and dwell are scrambled while RUN/FIN to prove they are ignored.
    for (int v = 0; v < 6; v++) begin
      push_start(vecs[v].mask, vecs[v].dwell, 1'b0);
      if (vecs[v].mask == 16'h0000) begin
        push_idle(20, 1'b1, 16'h0000);
      end else begin
        push_run(vecs[v].mask, vecs[v].dwell, 1'b0, vecs[v].tog, 1'b1, 16'h0, '0);
        push_tail();
      end
      run_sb(vecs[v].name, fd);
      check_int({vecs[v].name, "_done_cycle"}, fd, vecs[v].exp_done);
    end

    // Continuous mode: two 0x0003/dwell1 sweeps, wrap reloads 0x0010/dwell0, then cont=0 ends.
    push_start(16'h0003, 8'd1, 1'b1);
    push_run(16'h0003, 8'd1, 1'b1, 1'b0, 1'b0, 16'h0003, 8'd1);
    push_run(16'h0003, 8'd1, 1'b1, 1'b0, 1'b0, 16'h0010, 8'd0);
    push_run(16'h0010, 8'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'd0);
    push_tail();
    run_sb("cont_reload", fd);
    check_int("cont_reload_done_cycle", fd, 10);

    // Continuous wrap onto an empty mask drops to IDLE without done.
    push_start(16'h0002, 8'd0, 1'b1);
    push_run(16'h0002, 8'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'd0);
    push_idle(3, 1'b0, 16'h0000);
    run_sb("cont_empty_wrap", fd);
    check_int("cont_empty_wrap_done_cycle", fd, -1);

    // Abort in cycle 5 of a full sweep; the aborted channel's bit differs from its held value.
    push_start(16'hFFFF, 8'd0, 1'b0);
    push_run(16'h000F, 8'd0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 8'd0);
    push(1'b0, 1'b1, 1'b0, 1'b0, ~exp_hold[4], 16'hFFFF, 8'd0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    last_sel = 4'd4;
    push_idle(3, 1'b0, 16'hFFFF);
    push(1'b1, 1'b1, 1'b0, 1'b0, rbit(), 16'hFFFF, 8'd0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    push_idle(2, 1'b0, 16'hFFFF);
    run_sb("abort_c5", fd);
    check_int("abort_c5_done_cycle", fd, -1);

    // Reset during FIN: done visible that cycle, everything at reset values afterwards.
    push_start(16'h0040, 8'd0, 1'b0);
    push_run(16'h0040, 8'd0, 1'b0, 1'b0, 1'b0, 16'h0040, 8'd0);
    push(1'b1, 1'b1, 1'b0, 1'b1, rbit(), 16'hFFFF, 8'd0, 4'd6, 1'b0, 1'b1, 1'b1, 1'b0);
    last_sel = 4'd0;
    push_idle(2, 1'b0, 16'h0000);
    run_sb("rst_in_fin", fd);
    check_int("rst_in_fin_done_cycle", fd, 2);

    // Reset mid-sweep together with start: pending done suppressed, stays IDLE.
    push_start(16'h0300, 8'd2, 1'b0);
    push_run(16'h0100, 8'd2, 1'b0, 1'b0, 1'b0, 16'h0300, 8'd2);
    push(1'b1, 1'b0, 1'b0, 1'b1, rbit(), 16'hFFFF, 8'd0, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    last_sel = 4'd0;
    push_idle(20, 1'b0, 16'h0300);
    run_sb("rst_in_run", fd);
    check_int("rst_in_run_done_cycle", fd, -1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
